// File: rtl/oven_control_if.sv
// Panel and timer signal bundle for oven_control.
// master: panel buttons and timer feedback side; slave: the controller.
interface oven_control_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_start;
  logic       btn_stop;
  logic       door_open;
  logic [3:0] current_time;
  logic [3:0] set_time;
  logic       start_timer;
  logic       stop;
  logic       heater;
  logic       buzzer;
  logic [1:0] state;

  modport master (
    output btn_up, btn_down, btn_start, btn_stop, door_open, current_time,
    input  set_time, start_timer, stop, heater, buzzer, state
  );

  modport slave (
    input  btn_up, btn_down, btn_start, btn_stop, door_open, current_time,
    output set_time, start_timer, stop, heater, buzzer, state
  );
endinterface

// File: rtl/oven_control.sv
// Oven front-end: button conditioning, cook-time programming and timer control.
// Optional macro OVEN_HOLD_REPEAT_EN adds auto-repeat for held up/down buttons.
module oven_control #(
  parameter int MAX_TIME      = 15,
  parameter int DONE_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  oven_control_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  localparam int BW = $clog2(DONE_CYCLES + 1);

  genvar gi;

  state_t         state_reg, state_next;
  logic [3:0]     set_time_reg, set_time_next;
  logic [BW-1:0]  buzz_cnt_reg, buzz_cnt_next;
  logic           start_timer_reg, stop_reg, heater_reg, buzzer_reg;

  logic [4:0]     raw, lvl;
  logic [3:0]     press;
  logic           up_p, down_p, start_p, stop_p, door;
  logic           step_up, step_down;

  assign raw = {bus.door_open, bus.btn_stop, bus.btn_start, bus.btn_down, bus.btn_up};

  for (gi = 0; gi < 5; gi++) begin : g_sync
    logic s1_reg, s2_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else begin
        s1_reg <= raw[gi];
        s2_reg <= s1_reg;
      end
    end
    assign lvl[gi] = s2_reg;
  end

  // Registered edge pulse: a press sampled at edge k acts at edge k+3.
  for (gi = 0; gi < 4; gi++) begin : g_edge
    logic prev_reg, press_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_reg  <= 1'b0;
        press_reg <= 1'b0;
      end else begin
        prev_reg  <= lvl[gi];
        press_reg <= lvl[gi] & ~prev_reg;
      end
    end
    assign press[gi] = press_reg;
  end

  assign up_p    = press[0];
  assign down_p  = press[1];
  assign start_p = press[2];
  assign stop_p  = press[3];
  assign door    = lvl[4];

`ifdef OVEN_HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [1:0] held, rep_step;
  assign held = {g_edge[1].prev_reg, g_edge[0].prev_reg};

  // Armed by the press pulse so a hold carried in from another state never repeats.
  for (gi = 0; gi < 2; gi++) begin : g_rep
    logic          armed_reg;
    logic [RW-1:0] hold_cnt_reg;
    logic          hit;
    assign hit = armed_reg && held[gi] && (hold_cnt_reg == RW'(REPEAT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        armed_reg    <= 1'b0;
        hold_cnt_reg <= '0;
      end else if (state_reg != IDLE || !held[gi]) begin
        armed_reg    <= 1'b0;
        hold_cnt_reg <= '0;
      end else if (press[gi]) begin
        armed_reg    <= 1'b1;
        hold_cnt_reg <= '0;
      end else if (armed_reg) begin
        hold_cnt_reg <= hit ? '0 : hold_cnt_reg + 1'b1;
      end
    end
    assign rep_step[gi] = hit && !press[gi];
  end

  assign step_up   = up_p | rep_step[0];
  assign step_down = down_p | rep_step[1];
`else
  assign step_up   = up_p;
  assign step_down = down_p;
`endif

  always_comb begin
    state_next    = state_reg;
    set_time_next = set_time_reg;
    buzz_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        if (stop_p) begin
          state_next = IDLE;
        end else if (start_p) begin
          if (set_time_reg != 4'd0 && !door) state_next = RUN;
        end else if (step_up && !step_down) begin
          if (set_time_reg != 4'(MAX_TIME)) set_time_next = set_time_reg + 4'd1;
        end else if (step_down && !step_up) begin
          if (set_time_reg != 4'd0) set_time_next = set_time_reg - 4'd1;
        end
      end
      RUN: begin
        if (stop_p)                         state_next = IDLE;
        else if (door)                      state_next = PAUSE;
        else if (bus.current_time <= 4'd1)  state_next = DONE;
      end
      PAUSE: begin
        if (stop_p)                state_next = IDLE;
        else if (start_p && !door) state_next = RUN;
      end
      DONE: begin
        if (stop_p)                                        state_next = IDLE;
        else if (buzz_cnt_reg == BW'(DONE_CYCLES - 1))     state_next = IDLE;
        else                                               buzz_cnt_next = buzz_cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      set_time_reg    <= 4'd0;
      buzz_cnt_reg    <= '0;
      start_timer_reg <= 1'b0;
      stop_reg        <= 1'b1;
      heater_reg      <= 1'b0;
      buzzer_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      set_time_reg    <= set_time_next;
      buzz_cnt_reg    <= buzz_cnt_next;
      start_timer_reg <= (state_next == RUN);
      stop_reg        <= (state_next == IDLE);
      heater_reg      <= (state_next == RUN);
      buzzer_reg      <= (state_next == DONE);
    end
  end

  assign bus.state       = state_reg;
  assign bus.set_time    = set_time_reg;
  assign bus.start_timer = start_timer_reg;
  assign bus.stop        = stop_reg;
  assign bus.heater      = heater_reg;
  assign bus.buzzer      = buzzer_reg;

endmodule

// File: tb/tb_oven_control.sv
// Directed bench for oven_control with a behavioural countdown timer model.
module tb_oven_control;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] timer_reg;

  oven_control_if bus();

  oven_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Timer: reloads set_time while stop is high, counts down while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                timer_reg <= 4'd0;
    else if (bus.stop)                         timer_reg <= bus.set_time;
    else if (bus.start_timer && timer_reg != 0) timer_reg <= timer_reg - 4'd1;
  end
  assign bus.current_time = timer_reg;

  typedef struct {
    logic [3:0] btns;      // {stop, start, down, up}
    logic [3:0] exp_set;
    logic [1:0] exp_state;
    logic       exp_stop;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press; returns at the negedge right after the edge where it acts.
  task automatic press(input logic [3:0] m);
    bus.btn_up    = m[0];
    bus.btn_down  = m[1];
    bus.btn_start = m[2];
    bus.btn_stop  = m[3];
    tick(1);
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    tick(3);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 4'd1, 2'd0, 1'b1};
    vecs[1] = '{4'b0001, 4'd2, 2'd0, 1'b1};
    vecs[2] = '{4'b0001, 4'd3, 2'd0, 1'b1};
    vecs[3] = '{4'b0011, 4'd3, 2'd0, 1'b1};
    vecs[4] = '{4'b0010, 4'd2, 2'd0, 1'b1};
    vecs[5] = '{4'b0010, 4'd1, 2'd0, 1'b1};
    vecs[6] = '{4'b0010, 4'd0, 2'd0, 1'b1};
    vecs[7] = '{4'b0010, 4'd0, 2'd0, 1'b1};
    vecs[8] = '{4'b0010, 4'd0, 2'd0, 1'b1};
    vecs[9] = '{4'b0100, 4'd0, 2'd0, 1'b1};

    bus.btn_up = 0; bus.btn_down = 0; bus.btn_start = 0; bus.btn_stop = 0; bus.door_open = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", 8'(bus.state), 8'd0);
    check("rst_set_time", 8'(bus.set_time), 8'd0);
    check("rst_stop", 8'(bus.stop), 8'd1);
    check("rst_start_timer", 8'(bus.start_timer), 8'd0);
    check("rst_heater", 8'(bus.heater), 8'd0);
    check("rst_buzzer", 8'(bus.buzzer), 8'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 10; i++) begin
      press(vecs[i].btns);
      check($sformatf("vec%0d_set_time", i), 8'(bus.set_time), 8'(vecs[i].exp_set));
      check($sformatf("vec%0d_state", i), 8'(bus.state), 8'(vecs[i].exp_state));
      check($sformatf("vec%0d_stop", i), 8'(bus.stop), 8'(vecs[i].exp_stop));
      check($sformatf("vec%0d_heater", i), 8'(bus.heater), 8'd0);
    end

    // Saturation at the top
    for (int i = 0; i < 15; i++) press(4'b0001);
    check("up_to_max", 8'(bus.set_time), 8'd15);
    press(4'b0001);
    check("up_sat_max", 8'(bus.set_time), 8'd15);

    // Full cook cycle from 4
    for (int i = 0; i < 11; i++) press(4'b0010);
    check("set_four", 8'(bus.set_time), 8'd4);
    tick(1);
    check("timer_tracks", 8'(timer_reg), 8'd4);
    press(4'b0100);
    check("run_state", 8'(bus.state), 8'd1);
    check("run_heater", 8'(bus.heater), 8'd1);
    check("run_start_timer", 8'(bus.start_timer), 8'd1);
    check("run_stop", 8'(bus.stop), 8'd0);
    check("run_ct4", 8'(timer_reg), 8'd4);
    for (int t = 3; t >= 1; t--) begin
      tick(1);
      check($sformatf("run_ct%0d", t), 8'(timer_reg), 8'(t));
      check($sformatf("run_state_ct%0d", t), 8'(bus.state), 8'd1);
    end
    tick(1);
    check("done_ct0", 8'(timer_reg), 8'd0);
    check("done_state", 8'(bus.state), 8'd3);
    check("done_start_timer", 8'(bus.start_timer), 8'd0);
    check("done_heater", 8'(bus.heater), 8'd0);
    check("done_buzzer", 8'(bus.buzzer), 8'd1);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check($sformatf("buzz_cycle%0d", i + 2), 8'(bus.buzzer), 8'd1);
    end
    tick(1);
    check("buzz_end", 8'(bus.buzzer), 8'd0);
    check("back_idle", 8'(bus.state), 8'd0);
    check("back_stop", 8'(bus.stop), 8'd1);
    check("kept_set_time", 8'(bus.set_time), 8'd4);
    check("no_wrap", 8'(timer_reg), 8'd0);
    tick(1);
    check("reload_after_done", 8'(timer_reg), 8'd4);

    // Door opens right after start: pause with count held at 3
    bus.btn_start = 1'b1;
    tick(1);
    bus.btn_start = 1'b0;
    tick(1);
    bus.door_open = 1'b1;
    tick(2);
    check("pre_pause_run", 8'(bus.state), 8'd1);
    tick(1);
    check("pause_state", 8'(bus.state), 8'd2);
    check("pause_ct3", 8'(timer_reg), 8'd3);
    check("pause_heater", 8'(bus.heater), 8'd0);
    check("pause_stop", 8'(bus.stop), 8'd0);
    tick(3);
    check("pause_hold", 8'(timer_reg), 8'd3);
    press(4'b0100);
    check("start_door_open", 8'(bus.state), 8'd2);
    bus.door_open = 1'b0;
    tick(3);
    press(4'b0100);
    check("resume_state", 8'(bus.state), 8'd1);
    check("resume_ct3", 8'(timer_reg), 8'd3);
    tick(1);
    check("resume_ct2", 8'(timer_reg), 8'd2);

    // Stop and start together: stop wins
    press(4'b1100);
    check("stop_wins_state", 8'(bus.state), 8'd0);
    check("stop_wins_stop", 8'(bus.stop), 8'd1);
    tick(1);
    check("stop_reload", 8'(timer_reg), 8'd4);

    // Asynchronous reset mid-run
    press(4'b0100);
    check("rerun_state", 8'(bus.state), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", 8'(bus.state), 8'd0);
    check("async_set_time", 8'(bus.set_time), 8'd0);
    check("async_stop", 8'(bus.stop), 8'd1);
    check("async_start_timer", 8'(bus.start_timer), 8'd0);
    check("async_heater", 8'(bus.heater), 8'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("post_rst_idle", 8'(bus.state), 8'd0);

    // Hold up for 1+3*8 cycles
    bus.btn_up = 1'b1;
    tick(25);
    bus.btn_up = 1'b0;
    tick(8);
`ifdef OVEN_HOLD_REPEAT_EN
    check("hold_repeat", 8'(bus.set_time), 8'd4);
`else
    check("hold_single", 8'(bus.set_time), 8'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oven_control.md
Name: oven_control

Overview:
- Front-end controller and initiator for the countdown timer.
- Turns the up/down/start/stop buttons and the door switch into a set_time value and the timer control signals.
- Drives the heater and buzzer, and watches the timer's current_time count to detect the end of cooking.
- Sits between the panel inputs and the timer, in the same single clock domain.

Parameters:
- MAX_TIME, 15, upper saturation limit for set_time; must fit in 4 bits.
- DONE_CYCLES, 8, number of clk cycles buzzer stays high in DONE.
- REPEAT_CYCLES, 8, hold length before auto-repeat; used only with OVEN_HOLD_REPEAT_EN.

Ports:
- clk  in  1  system clock; the same clock as the timer.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw button that increments set_time.
- btn_down  in  1  raw button that decrements set_time.
- btn_start  in  1  raw button that starts or resumes cooking.
- btn_stop  in  1  raw button that aborts cooking.
- door_open  in  1  raw door switch; 1 means the door is open.
- current_time  in  4  remaining time fed back from the timer.
- set_time  out  4  programmed cook time; drives the timer's load value.
- start_timer  out  1  timer count enable.
- stop  out  1  timer load/reload request; the timer reloads set_time while this is high.
- heater  out  1  heating element enable.
- buzzer  out  1  end-of-cook alarm.
- state  out  2  encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset: rst_n low clears all outputs and registers immediately, with no clock needed. State goes to IDLE, set_time=0, start_timer=0, stop=1, heater=0, buzzer=0, buzz counter=0.
- Input conditioning: every button and door_open goes through a 2-FF synchronizer.
  - Buttons are then rising-edge detected, giving one press pulse per press.
  - A press on an input first sampled high at edge k acts at edge k+3.
  - door_open is used as the synchronized level.
- All outputs are registered.
- Event priority: stop > door > start > up/down.
- IDLE:
  - stop=1, start_timer=0, heater=0, buzzer=0. The timer therefore tracks set_time continuously.
  - An up press increments set_time, saturating at MAX_TIME; at MAX_TIME it holds.
  - A down press decrements set_time, saturating at 0.
  - Up and down pressed in the same cycle: no change.
  - A start press with set_time!=0 and the door closed moves to RUN. A start press with set_time==0 or the door open is ignored.
- RUN:
  - stop=0, start_timer=1, heater=1; set_time is frozen and up/down are ignored.
  - current_time<=1 moves to DONE, and start_timer drops at that same edge. The timer takes its final decrement to 0 on that edge and is never enabled at 0, so there is no wrap to 15.
  - door_open moves to PAUSE.
  - A stop press moves to IDLE, which reasserts stop and reloads the timer.
- PAUSE:
  - start_timer=0, heater=0, stop=0, so the timer holds its count.
  - A start press with the door closed moves to RUN.
  - A stop press moves to IDLE.
  - A start press while the door is still open is ignored.
- DONE:
  - buzzer=1, heater=0, start_timer=0, stop=0. The buzz counter runs from 0.
  - After DONE_CYCLES cycles, move to IDLE with buzzer=0 and stop=1.
  - A stop press exits to IDLE immediately.
  - set_time is retained, so the same time can be restarted.
- Reset mid-operation: asynchronous return to IDLE with the values above. Cooking is never resumed after reset.

Optional Feature:
- Macro: OVEN_HOLD_REPEAT_EN.
- Defined: in IDLE, holding btn_up or btn_down (synchronized level) for REPEAT_CYCLES consecutive cycles after its press pulse produces an extra step every REPEAT_CYCLES cycles. Steps still saturate at the same limits. Releasing the button clears the hold counter.
- Undefined: exactly one step per press, and no hold counter is synthesized.

Test Plan:
- Reset, then press up 3x -> set_time=3, stop=1, state=IDLE. Press down 5x -> set_time=0, held there by saturation.
- set_time=15, press up -> set_time stays 15. set_time=0, press start -> ignored, state stays IDLE.
- set_time=4 with timer model, press start -> RUN, heater=1.
  - current_time counts 4,3,2,1,0.
  - start_timer falls on the edge where current_time becomes 0; state=DONE.
  - buzzer is high for exactly 8 cycles, then IDLE with set_time=4.
- RUN with current_time=3, raise door_open -> PAUSE, current_time holds at 3, heater=0.
  - Press start with the door open -> ignored.
  - Close the door, press start -> RUN resumes from 3.
- RUN, press stop and start in the same cycle -> IDLE, stop=1, timer reloads set_time. Then drop rst_n mid-RUN -> all outputs go to reset values asynchronously.
- With OVEN_HOLD_REPEAT_EN, hold btn_up for 1+3*8 cycles from set_time=0 -> set_time=4. Without the macro -> set_time=1.
